// File: rtl/audio_pkg.sv
// Shared audio constants: default sample width, clock-divider bit positions, frame geometry.
package audio_pkg;

    localparam int unsigned DATA_WIDTH_DEF = 24;
    localparam int unsigned MCLK_BIT_DEF   = 1;
    localparam int unsigned SCLK_BIT_DEF   = 4;
    localparam int unsigned LRCK_BIT_DEF   = 10;

    localparam int unsigned SLOT_W  = 32;
    localparam int unsigned FRAME_W = 2 * SLOT_W;

    typedef logic [FRAME_W-1:0] frame_t;

endpackage

// File: rtl/i2s_tx_if.sv
// Stereo sample stream: one left/right pair per valid/ready handshake.
interface i2s_tx_if #(
    parameter int unsigned DATA_WIDTH = audio_pkg::DATA_WIDTH_DEF
);

    logic                  s_valid;
    logic                  s_ready;
    logic [DATA_WIDTH-1:0] s_left;
    logic [DATA_WIDTH-1:0] s_right;

    modport master (
        output s_valid,
        output s_left,
        output s_right,
        input  s_ready
    );

    modport slave (
        input  s_valid,
        input  s_left,
        input  s_right,
        output s_ready
    );

endinterface

// File: rtl/i2s_clock_gen.sv
// Free-running divider producing registered mclk/sclk/lrck plus bit and frame strobes.
module i2s_clock_gen
    import audio_pkg::*;
#(
    parameter int unsigned MCLK_BIT = MCLK_BIT_DEF,
    parameter int unsigned SCLK_BIT = SCLK_BIT_DEF,
    parameter int unsigned LRCK_BIT = LRCK_BIT_DEF
) (
    input  logic clk,
    input  logic reset,
    output logic mclk,
    output logic sclk,
    output logic lrck,
    output logic bit_tick,
    output logic frame_tick
);

    localparam int unsigned CNT_W = LRCK_BIT + 1;

    if (SCLK_BIT <= MCLK_BIT || LRCK_BIT != SCLK_BIT + 6) begin : g_bad_param
        $error("i2s_clock_gen: invalid counter bit positions");
    end

    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_nxt;

    assign cnt_nxt = cnt + CNT_W'(1);

    // Clock outputs are loaded from the next count so they track cnt exactly.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt  <= '0;
            mclk <= 1'b0;
            sclk <= 1'b0;
            lrck <= 1'b0;
        end else begin
            cnt  <= cnt_nxt;
            mclk <= cnt_nxt[MCLK_BIT];
            sclk <= cnt_nxt[SCLK_BIT];
            lrck <= cnt_nxt[LRCK_BIT];
        end
    end

    // Strobes mark the cycle before the sclk falling edge and the frame wrap.
    assign bit_tick   = &cnt[SCLK_BIT:0];
    assign frame_tick = &cnt;

endmodule

// File: rtl/i2s_tx.sv
// I2S transmitter: one-deep sample buffer feeding a 64-bit frame serializer.
module i2s_tx
    import audio_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = DATA_WIDTH_DEF,
    parameter int unsigned MCLK_BIT   = MCLK_BIT_DEF,
    parameter int unsigned SCLK_BIT   = SCLK_BIT_DEF,
    parameter int unsigned LRCK_BIT   = LRCK_BIT_DEF
) (
    input  logic       clk,
    input  logic       reset,
    i2s_tx_if.slave    bus,
    output logic       mclk,
    output logic       sclk,
    output logic       lrck,
    output logic       sdout,
    output logic       underrun
);

    localparam int unsigned PAD = SLOT_W - 1 - DATA_WIDTH;

    if (DATA_WIDTH < 1 || DATA_WIDTH > SLOT_W - 1) begin : g_bad_width
        $error("i2s_tx: DATA_WIDTH out of range");
    end

    logic bit_tick;
    logic frame_tick;

    i2s_clock_gen #(
        .MCLK_BIT (MCLK_BIT),
        .SCLK_BIT (SCLK_BIT),
        .LRCK_BIT (LRCK_BIT)
    ) u_clock_gen (
        .clk        (clk),
        .reset      (reset),
        .mclk       (mclk),
        .sclk       (sclk),
        .lrck       (lrck),
        .bit_tick   (bit_tick),
        .frame_tick (frame_tick)
    );

    // Each slot: a leading 0 (one-sclk I2S delay), the sample MSB-first, then zero pad.
    function automatic frame_t frame_image(input logic [DATA_WIDTH-1:0] l,
                                           input logic [DATA_WIDTH-1:0] r);
        logic [SLOT_W-1:0] ls;
        logic [SLOT_W-1:0] rs;
        ls = SLOT_W'({1'b0, l}) << PAD;
        rs = SLOT_W'({1'b0, r}) << PAD;
        return {ls, rs};
    endfunction

    logic                  pend_full;
    logic                  pend_full_nxt;
    logic [DATA_WIDTH-1:0] pend_l;
    logic [DATA_WIDTH-1:0] pend_l_nxt;
    logic [DATA_WIDTH-1:0] pend_r;
    logic [DATA_WIDTH-1:0] pend_r_nxt;
    frame_t                shift;
    frame_t                shift_nxt;
    frame_t                load_img;
    logic                  sdout_nxt;
    logic                  underrun_nxt;
    logic                  handshake;

    assign handshake = bus.s_valid & bus.s_ready;

    // Next-state: frame load priority is pending pair, then bypass, then silence.
    always_comb begin
        pend_full_nxt = pend_full;
        pend_l_nxt    = pend_l;
        pend_r_nxt    = pend_r;
        shift_nxt     = shift;
        sdout_nxt     = sdout;
        underrun_nxt  = 1'b0;
        load_img      = '0;

        if (frame_tick) begin
            if (pend_full) begin
                load_img      = frame_image(pend_l, pend_r);
                pend_full_nxt = 1'b0;
            end else if (handshake) begin
                load_img = frame_image(bus.s_left, bus.s_right);
            end else begin
                underrun_nxt = 1'b1;
            end
            sdout_nxt = load_img[FRAME_W-1];
            shift_nxt = {load_img[FRAME_W-2:0], 1'b0};
        end else if (bit_tick) begin
            sdout_nxt = shift[FRAME_W-1];
            shift_nxt = {shift[FRAME_W-2:0], 1'b0};
        end

        if (handshake && !frame_tick) begin
            pend_full_nxt = 1'b1;
            pend_l_nxt    = bus.s_left;
            pend_r_nxt    = bus.s_right;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pend_full   <= 1'b0;
            pend_l      <= '0;
            pend_r      <= '0;
            shift       <= '0;
            sdout       <= 1'b0;
            underrun    <= 1'b0;
            bus.s_ready <= 1'b0;
        end else begin
            pend_full   <= pend_full_nxt;
            pend_l      <= pend_l_nxt;
            pend_r      <= pend_r_nxt;
            shift       <= shift_nxt;
            sdout       <= sdout_nxt;
            underrun    <= underrun_nxt;
            bus.s_ready <= ~pend_full_nxt;
        end
    end

endmodule

// File: tb/tb_i2s_tx.sv
// Self-checking bench for i2s_tx against a frame-level reference model.
module tb_i2s_tx;

    logic clk;
    logic reset;
    logic mclk, sclk, lrck, sdout, underrun;

    i2s_tx_if #(.DATA_WIDTH(24)) bus ();

    i2s_tx #(.DATA_WIDTH(24)) dut (
        .clk      (clk),
        .reset    (reset),
        .bus      (bus),
        .mclk     (mclk),
        .sclk     (sclk),
        .lrck     (lrck),
        .sdout    (sdout),
        .underrun (underrun)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Reference model: counter position, buffered pair, frame currently on the wire.
    int unsigned c = 0;
    logic        m_pend = 1'b0;
    logic        m_ready = 1'b0;
    logic        m_under = 1'b0;
    logic        m_hs = 1'b0;
    logic [23:0] m_pl = '0;
    logic [23:0] m_pr = '0;
    logic [63:0] m_img = '0;

    function automatic logic [63:0] ref_image(input logic [23:0] l, input logic [23:0] r);
        return {1'b0, l, 7'b0, 1'b0, r, 7'b0};
    endfunction

    // Frame bit k is on the wire during the k-th 32-clk slot after the load edge.
    function automatic logic exp_sd();
        int idx;
        idx = 63 - int'(c / 32);
        return m_img[idx];
    endfunction

    function automatic logic cbit(input int b);
        return logic'((c >> b) & 1);
    endfunction

    task automatic clk_step();
        logic hs, ft;
        logic [23:0] l, r;
        ft = (c == 2047) && !reset;
        hs = bus.s_valid && m_ready && !reset;
        l  = bus.s_left;
        r  = bus.s_right;
        @(posedge clk);
        m_hs = hs;
        if (reset) begin
            c = 0; m_pend = 0; m_ready = 0; m_under = 0; m_img = '0;
        end else begin
            m_under = 0;
            if (ft) begin
                if (m_pend) begin
                    m_img = ref_image(m_pl, m_pr);
                    m_pend = 0;
                end else if (hs) begin
                    m_img = ref_image(l, r);
                end else begin
                    m_img = '0;
                    m_under = 1;
                end
            end else if (hs) begin
                m_pend = 1; m_pl = l; m_pr = r;
            end
            m_ready = !m_pend;
            c = (c + 1) % 2048;
        end
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        bus.s_valid = 1'b0;
        repeat (2) clk_step();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        bus.s_valid = 1'b1;
        bus.s_left = 24'h123456;
        bus.s_right = 24'h654321;
        repeat (3) clk_step();
        bus.s_valid = 1'b0;
        total += 6;
        if (mclk !== 1'b0) begin bad++; $display("FAIL reset_mclk got=%b want=0", mclk); end
        if (sclk !== 1'b0) begin bad++; $display("FAIL reset_sclk got=%b want=0", sclk); end
        if (lrck !== 1'b0) begin bad++; $display("FAIL reset_lrck got=%b want=0", lrck); end
        if (sdout !== 1'b0) begin bad++; $display("FAIL reset_sdout got=%b want=0", sdout); end
        if (underrun !== 1'b0) begin bad++; $display("FAIL reset_underrun got=%b want=0", underrun); end
        if (bus.s_ready !== 1'b0) begin bad++; $display("FAIL reset_ready got=%b want=0", bus.s_ready); end
        reset = 1'b0;
        clk_step();
        total += 2;
        if (bus.s_ready !== 1'b1) begin bad++; $display("FAIL release_ready got=%b want=1", bus.s_ready); end
        if (lrck !== 1'b0) begin bad++; $display("FAIL release_lrck got=%b want=0", lrck); end
    endtask

    task automatic test_known_pair();
        logic [63:0] word = '0;
        int n = 0;
        logic started = 1'b0;
        logic psclk;
        do_reset();
        while (c < 4) clk_step();
        bus.s_valid = 1'b1;
        bus.s_left  = 24'hA5A5A5;
        bus.s_right = 24'h5A5A5A;
        clk_step();
        bus.s_valid = 1'b0;
        total++;
        if (bus.s_ready !== 1'b0) begin bad++; $display("FAIL known_ready_drop got=%b want=0", bus.s_ready); end
        for (int i = 0; i < 4200 && n < 64; i++) begin
            psclk = sclk;
            clk_step();
            if (c == 0) started = 1'b1;
            total += 2;
            if (sdout !== exp_sd()) begin bad++; $display("FAIL known_sdout c=%0d got=%b want=%b", c, sdout, exp_sd()); end
            if (underrun !== m_under) begin bad++; $display("FAIL known_underrun c=%0d got=%b want=%b", c, underrun, m_under); end
            if (started && !psclk && sclk) begin
                word = {word[62:0], sdout};
                n++;
            end
        end
        total++;
        if (word !== 64'h52D2D280_2D2D2D00 || n != 64)
            begin bad++; $display("FAIL known_frame got=%h (%0d bits) want=52d2d2802d2d2d00", word, n); end
    endtask

    task automatic test_idle_underrun();
        int pulses = 0;
        do_reset();
        for (int i = 0; i < 3 * 2048 + 10; i++) begin
            clk_step();
            if (underrun === 1'b1) pulses++;
            total += 2;
            if (underrun !== m_under) begin bad++; $display("FAIL idle_underrun c=%0d got=%b want=%b", c, underrun, m_under); end
            if (sdout !== 1'b0) begin bad++; $display("FAIL idle_sdout c=%0d got=%b want=0", c, sdout); end
        end
        total++;
        if (pulses != 3) begin bad++; $display("FAIL idle_pulse_count got=%0d want=3", pulses); end
    endtask

    task automatic test_stream();
        int hs_cnt = 0;
        do_reset();
        bus.s_valid = 1'b1;
        bus.s_left  = 24'($urandom);
        bus.s_right = 24'($urandom);
        for (int i = 0; i < 4 * 2048 + 20; i++) begin
            clk_step();
            if (m_hs) begin
                hs_cnt++;
                bus.s_left  = 24'($urandom);
                bus.s_right = 24'($urandom);
            end
            total += 3;
            if (bus.s_ready !== m_ready) begin bad++; $display("FAIL stream_ready c=%0d got=%b want=%b", c, bus.s_ready, m_ready); end
            if (sdout !== exp_sd()) begin bad++; $display("FAIL stream_sdout c=%0d got=%b want=%b", c, sdout, exp_sd()); end
            if (underrun !== 1'b0) begin bad++; $display("FAIL stream_underrun c=%0d got=%b want=0", c, underrun); end
        end
        bus.s_valid = 1'b0;
        total++;
        if (hs_cnt != 5) begin bad++; $display("FAIL stream_handshakes got=%0d want=5", hs_cnt); end
    endtask

    task automatic test_bypass();
        logic [23:0] l, r;
        logic [63:0] word = '0;
        int n = 0;
        logic psclk;
        do_reset();
        for (int i = 0; i < 2100 && c != 2047; i++) clk_step();
        l = 24'($urandom);
        r = 24'($urandom);
        bus.s_valid = 1'b1;
        bus.s_left  = l;
        bus.s_right = r;
        clk_step();
        bus.s_valid = 1'b0;
        total += 2;
        if (underrun !== 1'b0) begin bad++; $display("FAIL bypass_underrun got=%b want=0", underrun); end
        if (bus.s_ready !== 1'b1) begin bad++; $display("FAIL bypass_ready got=%b want=1", bus.s_ready); end
        for (int i = 0; i < 2100 && n < 64; i++) begin
            psclk = sclk;
            clk_step();
            total++;
            if (sdout !== exp_sd()) begin bad++; $display("FAIL bypass_sdout c=%0d got=%b want=%b", c, sdout, exp_sd()); end
            if (!psclk && sclk) begin
                word = {word[62:0], sdout};
                n++;
            end
        end
        total++;
        if (word !== ref_image(l, r)) begin bad++; $display("FAIL bypass_frame got=%h want=%h", word, ref_image(l, r)); end
    endtask

    task automatic test_mid_reset();
        int pulses = 0;
        do_reset();
        repeat (3) clk_step();
        bus.s_valid = 1'b1;
        bus.s_left  = 24'($urandom);
        bus.s_right = 24'($urandom);
        clk_step();
        bus.s_valid = 1'b0;
        for (int i = 0; i < 2100 && c != 10; i++) clk_step();
        bus.s_valid = 1'b1;
        bus.s_left  = 24'($urandom) | 24'h800000;
        bus.s_right = 24'($urandom) | 24'h800000;
        clk_step();
        bus.s_valid = 1'b0;
        total++;
        if (bus.s_ready !== 1'b0) begin bad++; $display("FAIL midrst_pending_ready got=%b want=0", bus.s_ready); end
        for (int i = 0; i < 2100 && c != 1500; i++) begin
            clk_step();
            total++;
            if (sdout !== exp_sd()) begin bad++; $display("FAIL midrst_sdout c=%0d got=%b want=%b", c, sdout, exp_sd()); end
        end
        total++;
        if (lrck !== 1'b1) begin bad++; $display("FAIL midrst_right_channel got=%b want=1", lrck); end
        reset = 1'b1;
        clk_step();
        reset = 1'b0;
        total += 6;
        if (mclk !== 1'b0) begin bad++; $display("FAIL midrst_mclk got=%b want=0", mclk); end
        if (sclk !== 1'b0) begin bad++; $display("FAIL midrst_sclk got=%b want=0", sclk); end
        if (lrck !== 1'b0) begin bad++; $display("FAIL midrst_lrck got=%b want=0", lrck); end
        if (sdout !== 1'b0) begin bad++; $display("FAIL midrst_sdout0 got=%b want=0", sdout); end
        if (underrun !== 1'b0) begin bad++; $display("FAIL midrst_underrun0 got=%b want=0", underrun); end
        if (bus.s_ready !== 1'b0) begin bad++; $display("FAIL midrst_ready0 got=%b want=0", bus.s_ready); end
        clk_step();
        total++;
        if (bus.s_ready !== 1'b1) begin bad++; $display("FAIL midrst_ready_back got=%b want=1", bus.s_ready); end
        for (int i = 0; i < 2100; i++) begin
            clk_step();
            if (underrun === 1'b1) pulses++;
            total++;
            if (sdout !== 1'b0) begin bad++; $display("FAIL midrst_stale_sdout c=%0d got=%b want=0", c, sdout); end
        end
        total++;
        if (pulses != 1) begin bad++; $display("FAIL midrst_underrun_count got=%0d want=1", pulses); end
    endtask

    task automatic test_clock_ratio();
        int k = 0;
        int last_m = -1, last_s = -1, last_l = -1;
        logic pm, ps, pl;
        do_reset();
        for (int i = 0; i < 4200; i++) begin
            pm = mclk; ps = sclk; pl = lrck;
            clk_step();
            k++;
            total += 3;
            if (mclk !== cbit(1)) begin bad++; $display("FAIL ratio_mclk_phase c=%0d got=%b want=%b", c, mclk, cbit(1)); end
            if (sclk !== cbit(4)) begin bad++; $display("FAIL ratio_sclk_phase c=%0d got=%b want=%b", c, sclk, cbit(4)); end
            if (lrck !== cbit(10)) begin bad++; $display("FAIL ratio_lrck_phase c=%0d got=%b want=%b", c, lrck, cbit(10)); end
            if (!pm && mclk) begin
                if (last_m >= 0) begin
                    total++;
                    if (k - last_m != 4) begin bad++; $display("FAIL ratio_mclk_period got=%0d want=4", k - last_m); end
                end
                last_m = k;
            end
            if (!ps && sclk) begin
                if (last_s >= 0) begin
                    total++;
                    if (k - last_s != 32) begin bad++; $display("FAIL ratio_sclk_period got=%0d want=32", k - last_s); end
                end
                last_s = k;
            end
            if (!pl && lrck) begin
                if (last_l >= 0) begin
                    total++;
                    if (k - last_l != 2048) begin bad++; $display("FAIL ratio_lrck_period got=%0d want=2048", k - last_l); end
                end
                last_l = k;
            end
            if (pl !== lrck) begin
                total++;
                if (!(ps === 1'b1 && sclk === 1'b0)) begin bad++; $display("FAIL ratio_lrck_edge sclk %b->%b want 1->0", ps, sclk); end
            end
        end
        total++;
        if (last_l < 0) begin bad++; $display("FAIL ratio_lrck_seen got=none want=rising edge"); end
    endtask

    initial begin
        reset = 1'b1;
        bus.s_valid = 1'b0;
        bus.s_left  = '0;
        bus.s_right = '0;
        test_reset();
        test_known_pair();
        test_idle_underrun();
        test_stream();
        test_bypass();
        test_mid_reset();
        test_clock_ratio();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #3_000_000;
        $display("FAIL watchdog time limit reached");
        $fatal(1);
    end

endmodule

// File: doc/i2s_tx.md
I2S_TX -- requirements
Module: i2s_tx

Interface
REQ-001 Parameter DATA_WIDTH, default 24: audio sample width per channel, range 1..31.
REQ-002 Parameter MCLK_BIT, default 1: counter bit driving mclk (clk/4).
REQ-003 Parameter SCLK_BIT, default 4: counter bit driving sclk (clk/32); SHALL be greater than MCLK_BIT.
REQ-004 Parameter LRCK_BIT, default 10: counter bit driving lrck (clk/2048, 48.83 kHz at 100 MHz); SHALL equal SCLK_BIT+6, giving 32 sclk per channel.
REQ-005 Ports:
- clk  input  1  system clock; single clock domain.
- reset  input  1  synchronous, active-high reset.
- s_valid  input  1  stereo sample pair valid.
- s_ready  output  1  block can accept a pair.
- s_left  input  DATA_WIDTH  left sample, two's complement.
- s_right  input  DATA_WIDTH  right sample, two's complement.
- mclk  output  1  codec master clock.
- sclk  output  1  serial bit clock.
- lrck  output  1  word select; 0 = left, 1 = right.
- sdout  output  1  serial data to codec.
- underrun  output  1  one-clk pulse: frame started with no sample available.

Function
REQ-006 A free-running counter cnt of LRCK_BIT+1 bits SHALL increment every clk and wrap from all-ones to 0.
REQ-007 mclk, sclk and lrck SHALL be registered copies of cnt[MCLK_BIT], cnt[SCLK_BIT] and cnt[LRCK_BIT]; no combinational clock outputs.
REQ-008 bit_tick SHALL be 1 when cnt[SCLK_BIT:0] is all ones.
- The edge that bit_tick enables is the sclk falling edge.
REQ-009 frame_tick SHALL be 1 when all of cnt is all ones.
REQ-010 A one-deep pending buffer holds {s_left, s_right}; s_ready SHALL equal NOT pending_full.
REQ-011 A handshake occurs when s_valid and s_ready are both 1 at a rising clk edge.
- On a handshake without frame_tick, the pair SHALL be stored and pending_full set.
REQ-012 The frame image SHALL be 64 bits: {0, left, (31-DATA_WIDTH) zeros, 0, right, (31-DATA_WIDTH) zeros}.
- This places the MSB one sclk after each lrck transition (I2S delay) and zero-pads the remainder of each slot.
REQ-013 On frame_tick the 64-bit shift register SHALL load the image built from:
- the pending pair, if pending_full; pending_full then clears;
- otherwise the same-cycle handshake pair (bypass), with no underrun;
- otherwise all zeros, with underrun pulsed high for exactly that one clk.
REQ-014 On frame_tick, sdout SHALL take image bit 63 and the shift register SHALL hold the image shifted left by one.
- On any other bit_tick, sdout SHALL take shift[63] and the register SHALL shift left by one, filling with 0.
REQ-015 sdout SHALL change only on bit_tick edges; lrck and sdout change on the same edge.
REQ-016 Latency: the left MSB appears on sdout 32 clk (one sclk) after the frame_tick edge that loads the pair.
REQ-017 On a handshake coinciding with frame_tick while pending_full is 1, s_ready is 0 that cycle, so no handshake is possible; s_ready SHALL rise the clk after the load.

Reset
REQ-018 While reset is 1 at a clk edge, the following SHALL be 0: cnt, mclk, sclk, lrck, sdout, underrun, the shift register and pending_full.
- s_ready SHALL be 0 while reset is asserted and 1 on the first clk after release.
REQ-019 Reset mid-frame SHALL discard the pending and in-flight samples; output restarts from cnt=0 with zero data until the first frame_tick.

Structure
REQ-020 DATA_WIDTH default, the counter bit positions and the 64-bit frame width SHALL live in shared package audio_pkg.
REQ-021 The counter, clock outputs and tick strobes SHALL be a sub-module i2s_clock_gen.
- Ports: clk, reset, mclk, sclk, lrck, bit_tick, frame_tick.
- i2s_tx instantiates it and holds the buffer and serializer.

Verification
REQ-022 Reset, then present left=0xA5A5A5, right=0x5A5A5A at cycle 5 -> s_ready drops at cycle 6; after frame_tick at cycle 2047, sdout carries 0 then 101001011010010110100101 (left), 0 then 010110100101101001011010 (right), sampled on sclk rising edges, with zero padding.
REQ-023 No s_valid after reset -> underrun pulses for exactly one clk at cnt=2047 of every frame; sdout stays 0.
REQ-024 s_valid held 1 with incrementing samples -> exactly one handshake per 2048 clk after the first; no underrun; every frame carries the next sample.
REQ-025 Pending empty and s_valid asserted exactly on the frame_tick cycle -> bypass load; no underrun; the pair is transmitted in that frame.
REQ-026 reset asserted for 1 clk mid-right-channel -> all outputs 0 next clk; s_ready returns 1; the pending sample is not transmitted.
REQ-027 Clock-ratio check -> mclk period 4 clk, sclk period 32 clk, lrck period 2048 clk, lrck toggles on sclk falling edges.
